// File: rtl/ff_nn_seq_if.sv
// Sample/result handshake and weight-write port of the ff_nn_seq neuron layer.
interface ff_nn_seq_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int W     = 9,
  parameter int AW    = $clog2(N_OUT*(N_IN+1))
);
  logic              in_valid;
  logic              in_ready;
  logic [N_IN*W-1:0] x;
  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic [W-1:0]      w_data;
  logic              y_valid;
  logic              y_ready;
  logic [N_OUT-1:0]  y;

  modport master (
    output in_valid, x, w_we, w_addr, w_data, y_ready,
    input  in_ready, y_valid, y
  );
  modport slave (
    input  in_valid, x, w_we, w_addr, w_data, y_ready,
    output in_ready, y_valid, y
  );
endinterface

// File: rtl/ff_nn_seq.sv
// Sequential single-layer perceptron: one shared multiplier walks every
// (neuron, input) pair and applies a step activation per neuron.
module ff_nn_seq #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int W     = 9
) (
  input  logic       CLK,
  input  logic       RST,
  ff_nn_seq_if.slave bus
);
  localparam int ACC_W = 2*W + $clog2(N_IN+1);
  localparam int N_ENT = N_OUT*(N_IN+1);
  localparam int AW    = $clog2(N_ENT);
  localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  state_t                  state_r;
  logic signed [W-1:0]     wmem_r [N_ENT];
  logic [N_IN*W-1:0]       x_r;
  logic signed [ACC_W-1:0] acc_r;
  logic [IW-1:0]           i_r;
  logic [JW-1:0]           j_r;
  logic [N_OUT-1:0]        y_r;
  logic                    y_valid_r;
  logic                    in_ready_r;

  logic [AW-1:0]           w_idx_s;
  logic [AW-1:0]           b_next_idx_s;
  logic signed [W-1:0]     x_sel_s;
  logic signed [W-1:0]     w_sel_s;
  logic signed [2*W-1:0]   prod_s;
  logic signed [ACC_W-1:0] acc_next_s;
  logic signed [ACC_W-1:0] b_next_s;
  logic                    last_i_s;
  logic                    last_j_s;
  logic                    w_ok_s;

  function automatic logic signed [ACC_W-1:0] sext_w(input logic signed [W-1:0] v);
    return $signed({{(ACC_W-W){v[W-1]}}, v});
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_p(input logic signed [2*W-1:0] v);
    return $signed({{(ACC_W-2*W){v[2*W-1]}}, v});
  endfunction

  // Operand selection, shared multiply and next-bias lookup
  always_comb begin
    w_idx_s      = AW'(j_r) * AW'(N_IN+1) + AW'(i_r);
    b_next_idx_s = (AW'(j_r) + AW'(1)) * AW'(N_IN+1) + AW'(N_IN);
    x_sel_s      = x_r[int'(i_r)*W +: W];
    w_sel_s      = wmem_r[w_idx_s];
    prod_s       = x_sel_s * w_sel_s;
    acc_next_s   = acc_r + sext_p(prod_s);
    last_i_s     = (i_r == IW'(N_IN-1));
    last_j_s     = (j_r == JW'(N_OUT-1));
    w_ok_s       = bus.w_we && (state_r == IDLE) &&
                   ({1'b0, bus.w_addr} < (AW+1)'(N_ENT));
    if (last_j_s) begin
      b_next_s = {ACC_W{1'b0}};
    end else begin
      b_next_s = sext_w(wmem_r[b_next_idx_s]);
    end
  end

  // Weight/bias register file, writable only while idle
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int k = 0; k < N_ENT; k++) begin
        wmem_r[k] <= {W{1'b0}};
      end
    end else if (w_ok_s) begin
      wmem_r[bus.w_addr] <= bus.w_data;
    end
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b1;
      y_valid_r  <= 1'b0;
      y_r        <= {N_OUT{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      i_r        <= {IW{1'b0}};
      j_r        <= {JW{1'b0}};
      x_r        <= {(N_IN*W){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          // Bias read here sees the pre-write value if a write lands this edge
          if (bus.in_valid) begin
            x_r        <= bus.x;
            i_r        <= {IW{1'b0}};
            j_r        <= {JW{1'b0}};
            acc_r      <= sext_w(wmem_r[AW'(N_IN)]);
            state_r    <= MAC;
            in_ready_r <= 1'b0;
          end
        end
        MAC: begin
          if (last_i_s) begin
            y_r[j_r] <= ~acc_next_s[ACC_W-1];
            acc_r    <= b_next_s;
            i_r      <= {IW{1'b0}};
            if (last_j_s) begin
              j_r       <= {JW{1'b0}};
              state_r   <= OUT;
              y_valid_r <= 1'b1;
            end else begin
              j_r <= j_r + JW'(1);
            end
          end else begin
            acc_r <= acc_next_s;
            i_r   <= i_r + IW'(1);
          end
        end
        OUT: begin
          if (bus.y_ready) begin
            state_r    <= IDLE;
            y_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          y_valid_r  <= 1'b0;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.y_valid  = y_valid_r;
  assign bus.y        = y_r;

endmodule

// File: doc/ff_nn_seq.md
FF_NN_SEQ -- requirements
Module: ff_nn_seq

Interface
REQ-001 Parameter N_IN, default 4, number of signed inputs per sample.
REQ-002 Parameter N_OUT, default 2, number of neurons and output bits.
REQ-003 Parameter W, default 9, width of inputs, weights and biases (signed two's complement).
REQ-004 Derived ACC_W = 2*W + clog2(N_IN+1), default 21, accumulator width; AW = clog2(N_OUT*(N_IN+1)) weight address width.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RST  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  sample present on x.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 x  input  N_IN*W  packed signed inputs; x[i] = bits [i*W +: W].
REQ-010 w_we  input  1  weight/bias write strobe.
REQ-011 w_addr  input  AW  entry = j*(N_IN+1)+i; i<N_IN is weight w[j][i], i==N_IN is bias b[j].
REQ-012 w_data  input  W  signed value to write.
REQ-013 y_valid  output  1  result vector valid.
REQ-014 y_ready  input  1  consumer accepts result.
REQ-015 y  output  N_OUT  step-activated neuron outputs, y[j] for neuron j.

Function
REQ-016 The block SHALL hold an N_OUT*(N_IN+1) x W signed register file for weights and biases, and SHALL use one multiplier shared across all MAC steps.
REQ-017 The FSM SHALL have states IDLE, MAC, OUT; in_ready = 1 only in IDLE; y_valid = 1 only in OUT.
REQ-018 IDLE: on in_valid=1, capture x into an internal register, set neuron j=0, input i=0, acc = sign-extended b[0], go to MAC.
REQ-019 MAC, each cycle: acc <= acc + x[i]*w[j][i] (full-precision signed product, sign-extended to ACC_W); i increments.
REQ-020 MAC, when i==N_IN-1: y[j] <= 1 if the updated acc >= 0 else 0; acc <= b[j+1]; i <= 0; j increments; if j==N_OUT-1, go to OUT.
REQ-021 Latency: y_valid SHALL rise exactly N_IN*N_OUT edges after the accepting edge (default 8).
REQ-022 OUT: y and y_valid SHALL hold stable until y_ready=1; on that edge go to IDLE. No new sample is accepted in the same cycle.
REQ-023 The accumulator SHALL never overflow: ACC_W covers N_IN worst-case products plus bias.
REQ-024 The block SHALL apply a weight write (w_we=1) at the next edge only when state==IDLE and w_addr < N_OUT*(N_IN+1); otherwise it SHALL ignore the write.
REQ-025 If w_we and in_valid are both asserted in IDLE, the write SHALL take effect and the capture SHALL use the pre-write value for that entry; the new value applies to the next sample.
REQ-026 Changes to x after the accepting edge SHALL NOT affect the result.

Reset
REQ-027 On RST=0 at a rising edge, the block SHALL go to IDLE and set y=0, y_valid=0, acc=0, i=0, j=0, and all weights and biases to 0, regardless of the current state; in_ready SHALL be 1 in the first cycle after reset is released.
REQ-028 Reset during MAC or OUT SHALL abort the computation with no output.

Verification
REQ-029 After reset with no weight writes, x=(159,205,81,76) -> y_valid 8 edges later, y=2'b11 (acc=0 counts as >=0).
REQ-030 Write w[0]=(1,0,0,0), b[0]=-159, w[1]=(0,0,0,1), b[1]=-77, then x=(159,205,81,76) -> y[0]=1 (acc 0), y[1]=0 (acc -1).
REQ-031 Set all weights and x to -256 and biases to 255 -> both acc=262399, no overflow, y=2'b11.
REQ-032 Hold y_ready=0 for 20 cycles in OUT, with in_valid=1 and w_we=1 toggling -> y and y_valid stable, in_ready=0, weights unchanged; y_ready=1 -> IDLE next edge.
REQ-033 Assert RST=0 on the 4th MAC cycle -> next cycle shows IDLE, y=0, y_valid=0, and weights cleared (the re-run gives y=2'b11).
REQ-034 Write w_addr=10 (out of range for defaults) -> no entry changes; the REQ-030 result is unchanged.
